// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: pixel strobe, (x,y) requests,
// returned source colour, DAC pins and line/frame strobes.
interface vga_timing_gen_if #(
   parameter int CNT_W   = 11,
   parameter int COLOR_W = 4
);
   logic               pix_en;
   logic [CNT_W-1:0]   req_x;
   logic [CNT_W-1:0]   req_y;
   logic               req_de;
   logic [COLOR_W-1:0] src_r;
   logic [COLOR_W-1:0] src_g;
   logic [COLOR_W-1:0] src_b;
   logic [COLOR_W-1:0] vga_r;
   logic [COLOR_W-1:0] vga_g;
   logic [COLOR_W-1:0] vga_b;
   logic               vga_hs;
   logic               vga_vs;
   logic               line_start;
   logic               frame_start;

   modport master (
      input  pix_en, src_r, src_g, src_b,
      output req_x, req_y, req_de, vga_r, vga_g, vga_b, vga_hs, vga_vs,
             line_start, frame_start
   );

   modport slave (
      output pix_en, src_r, src_g, src_b,
      input  req_x, req_y, req_de, vga_r, vga_g, vga_b, vga_hs, vga_vs,
             line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, pixel requests, and a delay line
// that keeps sync and data-enable aligned with colour returned by the source.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int COLOR_W  = 4,
   parameter int PIPE_LAT = 1,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      h_d = h_q;
      v_d = v_q;
      if (vif.pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Raw timing, active-high, in {hs, vs, de} order through the delay line.
   logic [2:0] raw_tim;
   logic [2:0] dly_tim;

   assign raw_tim = {(h_q >= HS_START) && (h_q < HS_END),
                     (v_q >= VS_START) && (v_q < VS_END),
                     (h_q < H_ACT_END) && (v_q < V_ACT_END)};

   generate
      if (PIPE_LAT == 0) begin : g_no_dly
         assign dly_tim = raw_tim;
      end else begin : g_dly
         logic [2:0] pipe_q [PIPE_LAT];

         always_ff @(posedge clk) begin
            // NOTE: the delay line is reset, unlike a RAM, so the first frame starts blanked with syncs inactive.
            if (rst) begin
               for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
            end else if (vif.pix_en) begin
               pipe_q[0] <= raw_tim;
               for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign dly_tim = pipe_q[PIPE_LAT-1];
      end
   endgenerate

   logic [COLOR_W-1:0] vga_r_q, vga_r_d;
   logic [COLOR_W-1:0] vga_g_q, vga_g_d;
   logic [COLOR_W-1:0] vga_b_q, vga_b_d;
   logic               vga_hs_q, vga_hs_d;
   logic               vga_vs_q, vga_vs_d;

   // Blanking forces black regardless of what the source returns.
   always_comb begin
      vga_r_d  = dly_tim[0] ? vif.src_r : '0;
      vga_g_d  = dly_tim[0] ? vif.src_g : '0;
      vga_b_d  = dly_tim[0] ? vif.src_b : '0;
      vga_hs_d = H_POL ? dly_tim[2] : ~dly_tim[2];
      vga_vs_d = V_POL ? dly_tim[1] : ~dly_tim[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r_q  <= '0;
         vga_g_q  <= '0;
         vga_b_q  <= '0;
         vga_hs_q <= ~H_POL;
         vga_vs_q <= ~V_POL;
      end else if (vif.pix_en) begin
         vga_r_q  <= vga_r_d;
         vga_g_q  <= vga_g_d;
         vga_b_q  <= vga_b_d;
         vga_hs_q <= vga_hs_d;
         vga_vs_q <= vga_vs_d;
      end
   end

   assign vif.req_x       = h_q;
   assign vif.req_y       = v_q;
   assign vif.req_de      = raw_tim[0];
   assign vif.vga_r       = vga_r_q;
   assign vif.vga_g       = vga_g_q;
   assign vif.vga_b       = vga_b_q;
   assign vif.vga_hs      = vga_hs_q;
   assign vif.vga_vs      = vga_vs_q;
   assign vif.line_start  = vif.pix_en && (h_q == '0);
   assign vif.frame_start = vif.pix_en && (h_q == '0) && (v_q == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; expected values come from
// beat-count arithmetic over the raster rules.
module tb_vga_timing_gen;
   localparam int H_ACTIVE = 16, H_FP = 3, H_SYNC = 4, H_BP = 5;
   localparam int V_ACTIVE = 6,  V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam bit H_POL    = 1'b1;
   localparam bit V_POL    = 1'b0;
   localparam int PIPE_LAT = 2;
   localparam int CNT_W    = 11;
   localparam int COLOR_W  = 4;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME    = H_TOTAL * V_TOTAL;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.CNT_W(CNT_W), .COLOR_W(COLOR_W)) vif ();

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .H_POL(H_POL), .V_POL(V_POL), .COLOR_W(COLOR_W),
      .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vif(vif)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: n = pix_en beats since the last reset.
   int  n       = 0;
   bit  known   = 1'b0;
   bit  pattern = 1'b0;
   bit  counting = 1'b0;
   int  cyc     = 0;
   int  hs_cnt  = 0;
   int  vs_cnt  = 0;
   logic       exp_hs, exp_vs;
   logic [3:0] exp_r, exp_g, exp_b;
   int  ls_q[$];
   int  fs_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h (beat %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic int h_of(input int k);
      return k % H_TOTAL;
   endfunction

   function automatic int v_of(input int k);
      return (k / H_TOTAL) % V_TOTAL;
   endfunction

   task automatic step(input bit en, input bit r);
      int h, v, m;
      bit de_m, hs_m, vs_m;
      @(negedge clk);
      rst        = r;
      vif.pix_en = en;
      if (pattern && n >= PIPE_LAT) vif.src_r = 4'(h_of(n - PIPE_LAT));
      else                          vif.src_r = 4'($urandom);
      vif.src_g = 4'($urandom);
      vif.src_b = 4'($urandom);
      #1;
      if (known) begin
         h = h_of(n);
         v = v_of(n);
         check("req_x", vif.req_x, h);
         check("req_y", vif.req_y, v);
         check("req_de", vif.req_de, (h < H_ACTIVE) && (v < V_ACTIVE));
         check("line_start", vif.line_start, en && (h == 0));
         check("frame_start", vif.frame_start, en && (h == 0) && (v == 0));
      end
      if (vif.line_start === 1'b1)  ls_q.push_back(cyc);
      if (vif.frame_start === 1'b1) fs_q.push_back(cyc);
      @(posedge clk);
      cyc++;
      #1;
      if (r) begin
         n = 0;
         known = 1'b1;
         exp_hs = !H_POL;
         exp_vs = !V_POL;
         exp_r = '0; exp_g = '0; exp_b = '0;
      end else if (en) begin
         m = n - PIPE_LAT;
         de_m = 1'b0; hs_m = 1'b0; vs_m = 1'b0;
         if (m >= 0) begin
            h = h_of(m);
            v = v_of(m);
            de_m = (h < H_ACTIVE) && (v < V_ACTIVE);
            hs_m = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
            vs_m = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
         end
         exp_hs = hs_m ? H_POL : !H_POL;
         exp_vs = vs_m ? V_POL : !V_POL;
         exp_r  = de_m ? vif.src_r : 4'h0;
         exp_g  = de_m ? vif.src_g : 4'h0;
         exp_b  = de_m ? vif.src_b : 4'h0;
         if (pattern && de_m) exp_r = 4'(h);
         n++;
      end
      if (known) begin
         check("vga_hs", vif.vga_hs, exp_hs);
         check("vga_vs", vif.vga_vs, exp_vs);
         check("vga_r", vif.vga_r, exp_r);
         check("vga_g", vif.vga_g, exp_g);
         check("vga_b", vif.vga_b, exp_b);
      end
      if (counting) begin
         if (vif.vga_hs === H_POL) hs_cnt++;
         if (vif.vga_vs === V_POL) vs_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1;
      vif.pix_en = 1'b0;
      vif.src_r = '0; vif.src_g = '0; vif.src_b = '0;

      // Reset held for three clocks with pix_en high.
      repeat (3) step(1'b1, 1'b1);

      // Random pix_en gaps with random source colour over two frames.
      repeat (2 * FRAME + 50) step($urandom_range(0, 3) != 0, 1'b0);

      // Source returns x[3:0] PIPE_LAT beats late; vga_r must follow x in active video.
      pattern = 1'b1;
      repeat (3 * H_TOTAL) step(1'b1, 1'b0);
      pattern = 1'b0;

      // pix_en toggling every clock doubles the line period in clocks.
      ls_q.delete();
      for (int i = 0; i < 6 * H_TOTAL; i++) step(i % 2 == 0, 1'b0);
      check("ls_count", ls_q.size() >= 2, 1);
      if (ls_q.size() >= 2) check("line_period", ls_q[1] - ls_q[0], 2 * H_TOTAL);

      // Reset mid-frame at h=H_ACTIVE/2, v=V_ACTIVE/2.
      for (int i = 0; i < FRAME && (n % FRAME) != ((V_ACTIVE / 2) * H_TOTAL + H_ACTIVE / 2); i++)
         step(1'b1, 1'b0);
      check("mid_x", vif.req_x, H_ACTIVE / 2);
      check("mid_y", vif.req_y, V_ACTIVE / 2);
      step(1'b1, 1'b1);

      // First frame after reset: exact period and exact sync widths.
      fs_q.delete();
      hs_cnt = 0;
      vs_cnt = 0;
      counting = 1'b1;
      repeat (FRAME) step(1'b1, 1'b0);
      counting = 1'b0;
      repeat (5) step(1'b1, 1'b0);
      check("hs_beats", hs_cnt, H_SYNC * V_TOTAL);
      check("vs_beats", vs_cnt, V_SYNC * H_TOTAL);
      check("fs_count", fs_q.size() >= 2, 1);
      if (fs_q.size() >= 2) check("frame_period", fs_q[1] - fs_q[0], FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
